seg_digit_scanner: RTL and testbench
====================================

// Module: seg_digit_scanner
// PURPOSE
//  Parametrised, time-multiplexed digit scanner for the seven-segment display path.
//  Holds NUM_DIGITS packed digit values and steps through them at a programmable
//  refresh rate, driving the selected digit's value and a one-hot anode enable.
//  Inserts a blanking gap between digits to prevent ghosting.
//  Double-buffers new data (valid/ready) so a displayed frame never tears.
//  Sits between the value/BCD formatting logic and the seven-segment decoder.
// PARAMETERS
//  NUM_DIGITS   8       number of digits scanned (>=2)
//  DIGIT_W      4       bits per digit value
//  DIV          100000  clk cycles per digit slot (>=2)
//  BLANK_CYC    1000    blank cycles at start of each slot (0 <= BLANK_CYC < DIV)
//  ANODE_ACT_LO 1       1: anode active-low (Basys3); 0: active-high
// PORTS
//  clk        in   1                    system clock
//  rst        in   1                    asynchronous reset, active-high
//  din        in   NUM_DIGITS*DIGIT_W   packed digits, digit i = din[i*DIGIT_W +: DIGIT_W]
//  din_en     in   NUM_DIGITS           per-digit enable, captured with din (0 = digit dark)
//  din_valid  in   1                    new frame offered
//  din_ready  out  1                    pending buffer empty, can accept
//  digit_val  out  DIGIT_W              value of currently selected digit
//  digit_idx  out  clog2(NUM_DIGITS)    index of currently selected digit
//  anode      out  NUM_DIGITS           one-hot digit drive (polarity per ANODE_ACT_LO)
//  frame_pulse out 1                    1-cycle pulse when idx wraps to 0 (frame start)
// BEHAVIOUR
//  Reset: slot counter=0, idx=0, active buf=0, active en=0, pending empty,
//   din_ready=1, digit_val=0, anode all inactive, frame_pulse=0.
//  Slot counter cnt counts 0..DIV-1 every clk; at cnt==DIV-1 -> cnt=0, idx++.
//  idx wraps NUM_DIGITS-1 -> 0; that wrap cycle is the frame boundary.
//  States per slot: BLANK (cnt < BLANK_CYC), SHOW (cnt >= BLANK_CYC).
//   BLANK: anode all inactive. SHOW: anode[idx] active iff active_en[idx].
//   BLANK_CYC=0: BLANK never entered.
//  Outputs registered: anode, digit_val, digit_idx change 1 cycle after cnt/idx.
//  digit_val = active_buf[idx] via sub-module mux, valid in both states.
//  Handshake: accept when din_valid && din_ready; din/din_en -> pending, ready=0
//   next cycle. din_valid may drop any time; no accept while ready=0.
//  Frame boundary with pending full: pending -> active, pending cleared,
//   din_ready=1 next cycle; frame_pulse=1 the cycle idx becomes 0.
//  Accept in the same cycle as the boundary with pending empty: data goes to
//   pending, not active; shown from the following frame boundary.
//  Boundary with pending empty: active unchanged, scanning continues.
//  rst mid-frame: everything returns to reset values immediately (async);
//   pending data discarded; first SHOW after release is digit 0.
//  Widths: cnt = clog2(DIV) bits; no arithmetic beyond increment/compare.
// STRUCTURE
//  seg_scan_defs.vh: BLANK/SHOW state encoding, ANODE_OFF/ON helper macros.
//  Sub-module mux_n_bus #(N, W): combinational N:1 mux over packed bus,
//   generalises the existing fixed 8:1 4-bit mux; used for digit_val.
//  Top holds counter, state, idx, double buffer and output registers.
// TESTING (NUM_DIGITS=4, DIGIT_W=4, DIV=8, BLANK_CYC=2, ANODE_ACT_LO=1)
//  Reset released -> anode=4'b1111, digit_val=0, din_ready=1, first
//   frame_pulse after 32 cycles.
//  Load din=16'h4321, din_en=4'hF -> after next boundary digit0 shows 1
//   with anode=4'b1110 for 6 cycles, preceded by 2 cycles anode=4'b1111;
//   digits 1..3 show 2,3,4.
//  din_en=4'b0101 -> anode never drives digits 1,3 (those slots stay 4'b1111).
//  Offer two frames back-to-back -> second held (din_ready=0) until boundary;
//   neither frame tears mid-frame, second appears one frame later.
//  Accept exactly on boundary cycle -> data appears one frame later, not now.
//  Assert rst during digit 2 SHOW -> anode=4'b1111, pending lost, idx=0.

Source files
------------

// File: rtl/seg_digit_scanner_pkg.sv
// Shared types and helpers for the seven-segment digit scanner.
package seg_digit_scanner_pkg;

    typedef enum logic {
        StBlank = 1'b0,
        StShow  = 1'b1
    } slot_state_e;

    // Select/count width that stays at least one bit for degenerate sizes.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_digit_scanner_mux_n_bus.sv
// Combinational N:1 mux over a packed bus of W-bit lanes; lane i = bus[i*W +: W].
module mux_n_bus
    import seg_digit_scanner_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = 4,
    localparam int unsigned SEL_W = clog2_min1(N)
) (
    input  logic [N*W-1:0] bus,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]   y
);

    always_comb begin
        y = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                y = bus[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/seg_digit_scanner.sv
// Time-multiplexed digit scanner: per-slot blanking, one-hot anode drive and a
// double-buffered frame that only swaps at the frame boundary.
module seg_digit_scanner
    import seg_digit_scanner_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DIGIT_W      = 4,
    parameter int unsigned DIV          = 100000,
    parameter int unsigned BLANK_CYC    = 1000,
    parameter bit          ANODE_ACT_LO = 1'b1,
    localparam int unsigned IDX_W = clog2_min1(NUM_DIGITS),
    localparam int unsigned CNT_W = clog2_min1(DIV)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] din,
    input  logic [NUM_DIGITS-1:0]         din_en,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [DIGIT_W-1:0]            digit_val,
    output logic [IDX_W-1:0]              digit_idx,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic                          frame_pulse
);

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACT_LO}};

    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] active_buf_q, active_buf_d;
    logic [NUM_DIGITS-1:0]         active_en_q, active_en_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] pend_buf_q, pend_buf_d;
    logic [NUM_DIGITS-1:0]         pend_en_q, pend_en_d;
    logic                          pend_full_q, pend_full_d;

    logic [NUM_DIGITS-1:0]         anode_q, anode_d;
    logic [DIGIT_W-1:0]            digit_val_q;
    logic [IDX_W-1:0]              digit_idx_q;
    logic                          frame_pulse_q;

    slot_state_e                   state;
    logic                          slot_end;
    logic                          frame_end;
    logic                          accept;
    logic [DIGIT_W-1:0]            mux_val;
    logic [NUM_DIGITS-1:0]         onehot;

    if (BLANK_CYC == 0) begin : g_no_blank
        assign state = StShow;
    end else begin : g_blank
        assign state = (cnt_q < CNT_W'(BLANK_CYC)) ? StBlank : StShow;
    end

    assign slot_end  = (cnt_q == CNT_W'(DIV - 1));
    assign frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign accept    = din_valid && !pend_full_q;

    mux_n_bus #(
        .N (NUM_DIGITS),
        .W (DIGIT_W)
    ) u_val_mux (
        .bus (active_buf_q),
        .sel (idx_q),
        .y   (mux_val)
    );

    always_comb begin
        cnt_d        = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        active_buf_d = active_buf_q;
        active_en_d  = active_en_q;
        pend_buf_d   = pend_buf_q;
        pend_en_d    = pend_en_q;
        pend_full_d  = pend_full_q;

        if (slot_end) begin
            idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
        end

        // Swap only at the wrap so the displayed frame never tears.
        if (frame_end && pend_full_q) begin
            active_buf_d = pend_buf_q;
            active_en_d  = pend_en_q;
            pend_full_d  = 1'b0;
        end

        // accept implies pending empty, so it never collides with the swap above.
        if (accept) begin
            pend_buf_d  = din;
            pend_en_d   = din_en;
            pend_full_d = 1'b1;
        end
    end

    always_comb begin
        onehot        = '0;
        onehot[idx_q] = 1'b1;
        anode_d       = ANODE_OFF;
        case (state)
            StShow: begin
                if (active_en_q[idx_q]) begin
                    anode_d = onehot ^ ANODE_OFF;
                end
            end
            default: anode_d = ANODE_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            active_buf_q  <= '0;
            active_en_q   <= '0;
            pend_buf_q    <= '0;
            pend_en_q     <= '0;
            pend_full_q   <= 1'b0;
            anode_q       <= ANODE_OFF;
            digit_val_q   <= '0;
            digit_idx_q   <= '0;
            frame_pulse_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            active_buf_q  <= active_buf_d;
            active_en_q   <= active_en_d;
            pend_buf_q    <= pend_buf_d;
            pend_en_q     <= pend_en_d;
            pend_full_q   <= pend_full_d;
            anode_q       <= anode_d;
            digit_val_q   <= mux_val;
            digit_idx_q   <= idx_q;
            frame_pulse_q <= frame_end;
        end
    end

    assign din_ready   = !pend_full_q;
    assign digit_val   = digit_val_q;
    assign digit_idx   = digit_idx_q;
    assign anode       = anode_q;
    assign frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Directed bench for seg_digit_scanner (4 digits, DIV=8, BLANK_CYC=2, active-low anodes).
module tb_seg_digit_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic [3:0]  din_en;
    logic        din_valid;
    logic        din_ready;
    logic [3:0]  digit_val;
    logic [1:0]  digit_idx;
    logic [3:0]  anode;
    logic        frame_pulse;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    seg_digit_scanner #(
        .NUM_DIGITS   (4),
        .DIGIT_W      (4),
        .DIV          (8),
        .BLANK_CYC    (2),
        .ANODE_ACT_LO (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_en      (din_en),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .digit_val   (digit_val),
        .digit_idx   (digit_idx),
        .anode       (anode),
        .frame_pulse (frame_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic       v;
        logic [15:0] d;
        logic [3:0] e;
        logic [3:0] an;
        logic [3:0] val;
        logic [1:0] idx;
        logic       rdy;
        logic       pls;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        // cycle counts from reset release; outputs at cycle k reflect cnt/idx of cycle k-1
        vecs[0]  = '{1,   1'b0, 16'h0000, 4'h0, 4'hF, 4'h0, 2'd0, 1'b1, 1'b0};
        vecs[1]  = '{12,  1'b0, 16'h0000, 4'h0, 4'hF, 4'h0, 2'd1, 1'b1, 1'b0};
        vecs[2]  = '{31,  1'b0, 16'h0000, 4'h0, 4'hF, 4'h0, 2'd3, 1'b1, 1'b0};
        vecs[3]  = '{32,  1'b1, 16'h4321, 4'hF, 4'hF, 4'h0, 2'd3, 1'b1, 1'b1};
        vecs[4]  = '{33,  1'b1, 16'h8765, 4'h5, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{50,  1'b1, 16'h8765, 4'h5, 4'hF, 4'h0, 2'd2, 1'b0, 1'b0};
        vecs[6]  = '{64,  1'b1, 16'h8765, 4'h5, 4'hF, 4'h0, 2'd3, 1'b1, 1'b1};
        vecs[7]  = '{65,  1'b0, 16'h8765, 4'h5, 4'hF, 4'h1, 2'd0, 1'b0, 1'b0};
        vecs[8]  = '{67,  1'b0, 16'h8765, 4'h5, 4'hE, 4'h1, 2'd0, 1'b0, 1'b0};
        vecs[9]  = '{72,  1'b0, 16'h8765, 4'h5, 4'hE, 4'h1, 2'd0, 1'b0, 1'b0};
        vecs[10] = '{73,  1'b0, 16'h8765, 4'h5, 4'hF, 4'h2, 2'd1, 1'b0, 1'b0};
        vecs[11] = '{75,  1'b0, 16'h8765, 4'h5, 4'hD, 4'h2, 2'd1, 1'b0, 1'b0};
        vecs[12] = '{83,  1'b0, 16'h8765, 4'h5, 4'hB, 4'h3, 2'd2, 1'b0, 1'b0};
        vecs[13] = '{91,  1'b0, 16'h8765, 4'h5, 4'h7, 4'h4, 2'd3, 1'b0, 1'b0};
        vecs[14] = '{96,  1'b0, 16'h8765, 4'h5, 4'h7, 4'h4, 2'd3, 1'b1, 1'b1};
        vecs[15] = '{97,  1'b0, 16'h8765, 4'h5, 4'hF, 4'h5, 2'd0, 1'b1, 1'b0};
        vecs[16] = '{99,  1'b0, 16'h8765, 4'h5, 4'hE, 4'h5, 2'd0, 1'b1, 1'b0};
        vecs[17] = '{107, 1'b0, 16'h8765, 4'h5, 4'hF, 4'h6, 2'd1, 1'b1, 1'b0};
        vecs[18] = '{115, 1'b0, 16'h8765, 4'h5, 4'hB, 4'h7, 2'd2, 1'b1, 1'b0};
        vecs[19] = '{123, 1'b0, 16'h8765, 4'h5, 4'hF, 4'h8, 2'd3, 1'b1, 1'b0};
        vecs[20] = '{127, 1'b1, 16'hDCBA, 4'hF, 4'hF, 4'h8, 2'd3, 1'b1, 1'b0};
        vecs[21] = '{128, 1'b0, 16'hDCBA, 4'hF, 4'hF, 4'h8, 2'd3, 1'b0, 1'b1};
        vecs[22] = '{131, 1'b0, 16'hDCBA, 4'hF, 4'hE, 4'h5, 2'd0, 1'b0, 1'b0};
        vecs[23] = '{160, 1'b0, 16'hDCBA, 4'hF, 4'hF, 4'h8, 2'd3, 1'b1, 1'b1};
        vecs[24] = '{163, 1'b0, 16'hDCBA, 4'hF, 4'hE, 4'hA, 2'd0, 1'b1, 1'b0};
        vecs[25] = '{171, 1'b1, 16'h1111, 4'hF, 4'hD, 4'hB, 2'd1, 1'b1, 1'b0};

        rst       = 1'b1;
        din       = '0;
        din_en    = '0;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset anode", 32'(anode), 32'hF);
        check("reset digit_val", 32'(digit_val), 32'h0);
        check("reset digit_idx", 32'(digit_idx), 32'h0);
        check("reset din_ready", 32'(din_ready), 32'h1);
        check("reset frame_pulse", 32'(frame_pulse), 32'h0);
        rst = 1'b0;
        cyc = 0;

        for (int i = 0; i < 26; i++) begin
            while (cyc < vecs[i].at) tick();
            check($sformatf("v%0d anode", i), 32'(anode), 32'(vecs[i].an));
            check($sformatf("v%0d digit_val", i), 32'(digit_val), 32'(vecs[i].val));
            check($sformatf("v%0d digit_idx", i), 32'(digit_idx), 32'(vecs[i].idx));
            check($sformatf("v%0d din_ready", i), 32'(din_ready), 32'(vecs[i].rdy));
            check($sformatf("v%0d frame_pulse", i), 32'(frame_pulse), 32'(vecs[i].pls));
            din_valid = vecs[i].v;
            din       = vecs[i].d;
            din_en    = vecs[i].e;
        end

        // Frame 16'h1111 accepted into pending, then reset lands during digit 2 SHOW.
        tick();
        check("pending loaded ready", 32'(din_ready), 32'h0);
        din_valid = 1'b0;
        while (cyc < 179) tick();
        check("digit2 show anode", 32'(anode), 32'hB);
        check("digit2 show val", 32'(digit_val), 32'hC);
        rst = 1'b1;
        #1;
        check("async rst anode", 32'(anode), 32'hF);
        check("async rst idx", 32'(digit_idx), 32'h0);
        check("async rst val", 32'(digit_val), 32'h0);
        check("async rst ready", 32'(din_ready), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;

        while (cyc < 3) tick();
        check("post rst first show idx", 32'(digit_idx), 32'h0);
        check("post rst first show anode", 32'(anode), 32'hF);

        begin
            int waited;
            waited = 0;
            while (!frame_pulse && waited < 40) begin
                tick();
                waited++;
            end
            check("post rst pulse seen", 32'(frame_pulse), 32'h1);
            check("post rst pulse cycle", 32'(cyc), 32'd32);
        end

        while (cyc < 35) tick();
        check("pending lost anode", 32'(anode), 32'hF);
        check("pending lost val", 32'(digit_val), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
